// File: rtl/dft_jig_tester.sv
// ============================================================================
// dft_jig_tester : board DFT loopback checker (opens/shorts/stuck-lows) plus
//                  DUT slow-clock half-period measurement.
// Rev 1.0
// ============================================================================
`default_nettype none

module dft_jig_tester #(
  parameter int NUM_PAIRS       = 11,
  parameter int SETTLE_CYCLES   = 48,
  parameter int EXP_HALF_PERIOD = 1000001,
  parameter int HALF_PERIOD_TOL = 1000,
  parameter int EDGE_TIMEOUT    = 4000000
) (
  input  logic                 clk_48mhz,
  input  logic                 rst_n,
  input  logic                 start,
  output logic [NUM_PAIRS-1:0] stim_oe,
  input  logic [NUM_PAIRS-1:0] resp_in,
  input  logic                 dut_sck_in,
  output logic                 busy,
  output logic                 done,
  output logic                 pass,
  output logic [NUM_PAIRS-1:0] pair_fail,
  output logic                 clk_fail,
  output logic [23:0]          measured_half_period
);

  localparam int                 c_KW        = (NUM_PAIRS > 1) ? $clog2(NUM_PAIRS) : 1;
  localparam logic [c_KW-1:0]    c_LAST_K    = c_KW'(NUM_PAIRS - 1);
  localparam logic [NUM_PAIRS-1:0] c_ONE     = NUM_PAIRS'(1);
  localparam logic [23:0]        c_SAT       = 24'hFFFFFF;
  localparam logic [23:0]        c_PHASE_END = 24'(SETTLE_CYCLES - 1);
  localparam logic [23:0]        c_TIMEOUT   = 24'(EDGE_TIMEOUT - 1);
  localparam logic [25:0]        c_EXP       = 26'(EXP_HALF_PERIOD);
  localparam logic [25:0]        c_TOL       = 26'(HALF_PERIOD_TOL);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_BASELINE = 3'd1,
    S_DRIVE    = 3'd2,
    S_RELEASE  = 3'd3,
    S_CLK_SYNC = 3'd4,
    S_CLK_MEAS = 3'd5,
    S_DONE     = 3'd6
  } state_t;

  state_t               r_state;
  state_t               w_next;
  logic [23:0]          r_cnt;
  logic [c_KW-1:0]      r_k;
  logic [NUM_PAIRS-1:0] r_resp_s1, r_resp_s2;
  logic                 r_sck_s1, r_sck_s2, r_sck_prev;
  logic [NUM_PAIRS-1:0] r_stuck;
  logic [NUM_PAIRS-1:0] r_pair_fail;
  logic                 r_clk_fail;
  logic [23:0]          r_meas;

  logic                 w_phase_end;
  logic                 w_timeout;
  logic                 w_edge;
  logic                 w_start_run;
  logic [NUM_PAIRS-1:0] w_onehot;
  logic [NUM_PAIRS-1:0] w_open;
  logic [NUM_PAIRS-1:0] w_short;
  logic [23:0]          w_meas;
  logic                 w_out_tol;

  assign w_phase_end = (r_cnt == c_PHASE_END);
  assign w_timeout   = (r_cnt == c_TIMEOUT);
  assign w_edge      = r_sck_s2 ^ r_sck_prev;
  assign w_start_run = start && ((r_state == S_IDLE) || (r_state == S_DONE));
  assign w_onehot    = c_ONE << r_k;
  assign w_open      = w_onehot & r_resp_s2;
  // Pins already stuck low at baseline are not evidence of a short.
  assign w_short     = ~r_resp_s2 & ~w_onehot & ~r_stuck;
  assign w_meas      = (r_cnt == c_SAT) ? c_SAT : r_cnt + 24'd1;
  assign w_out_tol   = ({2'b00, w_meas} > c_EXP + c_TOL) ||
                       ({2'b00, w_meas} + c_TOL < c_EXP);

  always_ff @(posedge clk_48mhz or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next               = r_state;
    busy                 = 1'b0;
    done                 = 1'b0;
    pass                 = 1'b0;
    stim_oe              = '0;
    pair_fail            = r_pair_fail;
    clk_fail             = r_clk_fail;
    measured_half_period = r_meas;
    case (r_state)
      S_IDLE: begin
        if (start) w_next = S_BASELINE;
      end
      S_BASELINE: begin
        busy = 1'b1;
        if (w_phase_end) w_next = S_DRIVE;
      end
      S_DRIVE: begin
        busy    = 1'b1;
        stim_oe = w_onehot;
        if (w_phase_end) w_next = S_RELEASE;
      end
      S_RELEASE: begin
        busy = 1'b1;
        if (w_phase_end) w_next = (r_k == c_LAST_K) ? S_CLK_SYNC : S_DRIVE;
      end
      S_CLK_SYNC: begin
        busy = 1'b1;
        if (w_edge) w_next = S_CLK_MEAS;
        else if (w_timeout) w_next = S_DONE;
      end
      S_CLK_MEAS: begin
        busy = 1'b1;
        if (w_edge || w_timeout) w_next = S_DONE;
      end
      S_DONE: begin
        done = 1'b1;
        pass = (r_pair_fail == '0) && !r_clk_fail;
        if (start) w_next = S_BASELINE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_48mhz or negedge rst_n) begin
    if (!rst_n) begin
      r_resp_s1   <= '0;
      r_resp_s2   <= '0;
      r_sck_s1    <= 1'b0;
      r_sck_s2    <= 1'b0;
      r_sck_prev  <= 1'b0;
      r_cnt       <= '0;
      r_k         <= '0;
      r_stuck     <= '0;
      r_pair_fail <= '0;
      r_clk_fail  <= 1'b0;
      r_meas      <= '0;
    end else begin
      r_resp_s1  <= resp_in;
      r_resp_s2  <= r_resp_s1;
      r_sck_s1   <= dut_sck_in;
      r_sck_s2   <= r_sck_s1;
      r_sck_prev <= r_sck_s2;

      // Every phase entry is a state change, so this reloads the counter.
      if (w_next != r_state) r_cnt <= '0;
      else if (r_cnt != c_SAT) r_cnt <= r_cnt + 24'd1;

      if (w_start_run) begin
        r_k         <= '0;
        r_stuck     <= '0;
        r_pair_fail <= '0;
        r_clk_fail  <= 1'b0;
        r_meas      <= '0;
      end

      case (r_state)
        S_BASELINE: begin
          if (w_phase_end) begin
            r_stuck     <= ~r_resp_s2;
            r_pair_fail <= r_pair_fail | ~r_resp_s2;
          end
        end
        S_DRIVE: begin
          if (w_phase_end)
            r_pair_fail <= r_pair_fail | w_open | w_short |
                           ((w_short != '0) ? w_onehot : '0);
        end
        S_RELEASE: begin
          if (w_phase_end && (r_k != c_LAST_K)) r_k <= r_k + 1'b1;
        end
        S_CLK_SYNC: begin
          if (!w_edge && w_timeout) begin
            r_clk_fail <= 1'b1;
            r_meas     <= c_SAT;
          end
        end
        S_CLK_MEAS: begin
          if (w_edge) begin
            r_meas     <= w_meas;
            r_clk_fail <= w_out_tol;
          end else if (w_timeout) begin
            r_clk_fail <= 1'b1;
            r_meas     <= c_SAT;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_dft_jig_tester.sv
// ============================================================================
// tb_dft_jig_tester : table-driven and randomized checks of dft_jig_tester
//                     against a pin-level fault model of the board.
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_dft_jig_tester;

  localparam int N = 4;

  typedef struct {
    logic [N-1:0] open_m;
    logic [N-1:0] stuck_m;
    bit           sh_en;
    int           sh_a;
    int           sh_b;
    int           half;
  } fault_t;

  typedef struct {
    fault_t       f;
    logic [N-1:0] pf;
    bit           cf;
    logic [23:0]  meas;
  } vec_t;

  logic         clk_48mhz = 1'b0;
  logic         rst_n;
  logic         start;
  logic [N-1:0] stim_oe;
  logic [N-1:0] resp_in;
  logic         dut_sck_in = 1'b0;
  logic         busy, done, pass, clk_fail;
  logic [N-1:0] pair_fail;
  logic [23:0]  measured_half_period;

  int     errors = 0;
  int     checks = 0;
  fault_t cur;
  int     sck_cnt = 0;

  dft_jig_tester #(
    .NUM_PAIRS(N), .SETTLE_CYCLES(8), .EXP_HALF_PERIOD(100),
    .HALF_PERIOD_TOL(2), .EDGE_TIMEOUT(400)
  ) dut (
    .clk_48mhz(clk_48mhz), .rst_n(rst_n), .start(start), .stim_oe(stim_oe),
    .resp_in(resp_in), .dut_sck_in(dut_sck_in), .busy(busy), .done(done),
    .pass(pass), .pair_fail(pair_fail), .clk_fail(clk_fail),
    .measured_half_period(measured_half_period)
  );

  always #5 clk_48mhz = ~clk_48mhz;

  // Board model: a pin reads low while its stimulus is driven, modified by faults.
  function automatic logic [N-1:0] resp_of(input logic [N-1:0] stim, input fault_t f);
    logic [N-1:0] r;
    logic v;
    r = ~stim | f.open_m;
    if (f.sh_en) begin
      v = ~(stim[f.sh_a] | stim[f.sh_b]);
      r[f.sh_a] = v;
      r[f.sh_b] = v;
    end
    return r & ~f.stuck_m;
  endfunction

  always_comb resp_in = resp_of(stim_oe, cur);

  always @(posedge clk_48mhz) begin
    if (cur.half > 0) begin
      if (sck_cnt >= cur.half - 1) begin
        dut_sck_in <= ~dut_sck_in;
        sck_cnt    <= 0;
      end else begin
        sck_cnt <= sck_cnt + 1;
      end
    end
  end

  always @(negedge clk_48mhz) begin
    assert ($onehot0(stim_oe)) else begin
      errors++;
      $display("FAIL stim_onehot: got %b required at most one bit set", stim_oe);
    end
  end

  function automatic logic [N-1:0] model_pf(input fault_t f);
    logic [N-1:0] stuck, pf, r, oh, others;
    stuck = ~resp_of('0, f);
    pf = stuck;
    for (int k = 0; k < N; k++) begin
      oh = '0;
      oh[k] = 1'b1;
      r = resp_of(oh, f);
      if (r[k]) pf[k] = 1'b1;
      others = ~r & ~oh & ~stuck;
      if (others != '0) pf = pf | others | oh;
    end
    return pf;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  task automatic pulse_start();
    @(negedge clk_48mhz) start = 1'b1;
    @(negedge clk_48mhz) start = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int n;
    n = 0;
    while (!done && n < 3000) begin
      @(negedge clk_48mhz);
      n++;
    end
    checks++;
    if (!done) begin
      errors++;
      $display("FAIL %s_done_timeout: got done=0 required done=1 within 3000 cycles", tag);
    end
  endtask

  task automatic check_results(input vec_t v, input string tag);
    chk({tag, "_done"}, 32'(done), 32'd1);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_pair_fail"}, 32'(pair_fail), 32'(v.pf));
    chk({tag, "_clk_fail"}, 32'(clk_fail), 32'(v.cf));
    chk({tag, "_measured"}, 32'(measured_half_period), 32'(v.meas));
    chk({tag, "_pass"}, 32'(pass), 32'((v.pf == '0) && !v.cf));
  endtask

  task automatic run_vec(input vec_t v, input string tag);
    cur = v.f;
    repeat (3) @(negedge clk_48mhz);
    pulse_start();
    wait_done(tag);
    check_results(v, tag);
  endtask

  vec_t   tbl[6];
  fault_t ideal;

  initial begin
    ideal = '{open_m: '0, stuck_m: '0, sh_en: 0, sh_a: 0, sh_b: 0, half: 100};
    tbl[0] = '{f: ideal, pf: 4'b0000, cf: 0, meas: 24'd100};
    tbl[1] = '{f: '{open_m: 4'b0100, stuck_m: '0, sh_en: 0, sh_a: 0, sh_b: 0, half: 100},
               pf: 4'b0100, cf: 0, meas: 24'd100};
    tbl[2] = '{f: '{open_m: '0, stuck_m: '0, sh_en: 1, sh_a: 1, sh_b: 3, half: 100},
               pf: 4'b1010, cf: 0, meas: 24'd100};
    tbl[3] = '{f: '{open_m: '0, stuck_m: 4'b0001, sh_en: 0, sh_a: 0, sh_b: 0, half: 100},
               pf: 4'b0001, cf: 0, meas: 24'd100};
    tbl[4] = '{f: '{open_m: '0, stuck_m: '0, sh_en: 0, sh_a: 0, sh_b: 0, half: 110},
               pf: 4'b0000, cf: 1, meas: 24'd110};
    tbl[5] = '{f: '{open_m: '0, stuck_m: '0, sh_en: 0, sh_a: 0, sh_b: 0, half: 0},
               pf: 4'b0000, cf: 1, meas: 24'hFFFFFF};

    cur   = ideal;
    rst_n = 1'b0;
    start = 1'b0;
    repeat (4) @(negedge clk_48mhz);
    chk("reset_outputs", {busy, done, pass, clk_fail, pair_fail, stim_oe},
        32'd0);
    chk("reset_measured", 32'(measured_half_period), 32'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk_48mhz);

    // Stimulus walk, with start re-pulsed mid-run (must be ignored).
    begin
      int nbad;
      logic [N-1:0] e;
      nbad = 0;
      pulse_start();
      for (int i = 0; i < 72; i++) begin
        if (i > 0) @(negedge clk_48mhz);
        e = '0;
        if ((i / 8) % 2 == 1) e[(i / 8 - 1) / 2] = 1'b1;
        if (stim_oe !== e || busy !== 1'b1) begin
          nbad++;
          if (nbad < 4) $display("FAIL stim_seq[%0d]: got %b busy=%b required %b busy=1", i, stim_oe, busy, e);
        end
        start = (i == 20 || i == 50);
      end
      start = 1'b0;
      chk("stim_sequence_errors", 32'(nbad), 32'd0);
      wait_done("seq");
      check_results(tbl[0], "seq");
    end

    for (int i = 0; i < 6; i++) run_vec(tbl[i], $sformatf("tbl%0d", i));

    // Restart from DONE after a failing run: results clear, run repeats.
    cur = ideal;
    repeat (3) @(negedge clk_48mhz);
    @(negedge clk_48mhz) start = 1'b1;
    @(negedge clk_48mhz) start = 1'b0;
    chk("restart_cleared", {busy, done, pass, clk_fail, pair_fail}, 32'b1_0_0_0_0000);
    chk("restart_meas_cleared", 32'(measured_half_period), 32'd0);
    wait_done("restart");
    check_results(tbl[0], "restart");

    // Asynchronous reset during DRIVE(2).
    begin
      int n;
      pulse_start();
      n = 0;
      while (stim_oe !== 4'b0100 && n < 500) begin
        @(negedge clk_48mhz);
        n++;
      end
      chk("reach_drive2", 32'(stim_oe), 32'b0100);
      #1 rst_n = 1'b0;
      #1;
      chk("midrst_stim_async", 32'(stim_oe), 32'd0);
      chk("midrst_busy_done", {busy, done, pass}, 32'd0);
      chk("midrst_pair_fail", 32'(pair_fail), 32'd0);
      @(negedge clk_48mhz) rst_n = 1'b1;
      repeat (3) @(negedge clk_48mhz);
      chk("midrst_stays_idle", {busy, done}, 32'd0);
    end

    // Randomized board faults against the model.
    for (int it = 0; it < 10; it++) begin
      vec_t v;
      int a, b;
      v.f.open_m  = 4'($urandom) & 4'($urandom);
      v.f.stuck_m = 4'($urandom) & 4'($urandom) & 4'($urandom);
      v.f.sh_en   = ($urandom_range(0, 2) == 0);
      a = $urandom_range(0, N - 1);
      b = (a + $urandom_range(1, N - 1)) % N;
      v.f.sh_a = a;
      v.f.sh_b = b;
      v.f.half = ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(95, 106);
      v.pf   = model_pf(v.f);
      v.cf   = (v.f.half == 0) || (v.f.half > 102) || (v.f.half < 98);
      v.meas = (v.f.half == 0) ? 24'hFFFFFF : 24'(v.f.half);
      run_vec(v, $sformatf("rnd%0d", it));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/dft_jig_tester.md
Name: dft_jig_tester

Overview:
- Test-jig side of the board DFT loopback.
- The DUT bitstream pulls each response pin low while its paired stimulus pin is low, and toggles a divided slow clock on the sck pin.
- This block walks the stimulus pins one at a time, checks every response pin for opens, shorts and stuck-lows, and measures the DUT slow-clock half-period.
- Runs on the jig FPGA; results go to a status register/LED driver.

Parameters:
- NUM_PAIRS, 11, number of stimulus/response pin pairs.
- SETTLE_CYCLES, 48, clk cycles per phase before sampling (minimum 4).
- EXP_HALF_PERIOD, 1000001, expected DUT slow-clock half-period in clk cycles.
- HALF_PERIOD_TOL, 1000, allowed absolute deviation from EXP_HALF_PERIOD.
- EDGE_TIMEOUT, 4000000, maximum cycles to wait for any sck edge.

Ports:
- clk_48mhz  input  1  sole clock.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  single-cycle pulse; begins a test run.
- stim_oe  output  NUM_PAIRS  bit k=1 drives stimulus pin k low (open-drain enable; pad pulls up when 0).
- resp_in  input  NUM_PAIRS  response pins, asynchronous, pulled up.
- dut_sck_in  input  1  DUT slow clock, asynchronous.
- busy  output  1  run in progress.
- done  output  1  run complete; results valid.
- pass  output  1  done, with no pair_fail bits set and clk_fail=0.
- pair_fail  output  NUM_PAIRS  per-pair failure flags.
- clk_fail  output  1  slow-clock half-period out of tolerance, or no edge seen.
- measured_half_period  output  24  last measured half-period, in clk cycles.

Behaviour:
- Clock and reset: one clock, clk_48mhz. Reset rst_n is asynchronous and active-low.
- Reset values: all outputs 0. stim_oe releases asynchronously on reset assertion, including mid-run.
- Synchronisers: resp_in and dut_sck_in each pass through a 2-flop synchroniser. All checks use the synchronised values.
- IDLE: start=1 clears pair_fail, clk_fail, done, pass and measured_half_period. FSM goes to BASELINE; busy=1 from the next cycle.
- start is ignored while busy. In DONE, start restarts the run identically to IDLE.
- BASELINE: stim_oe=0 for SETTLE_CYCLES cycles. Sample on the last cycle: any resp[j]=0 sets pair_fail[j] (stuck-low). Then go to DRIVE with k=0.
- DRIVE(k): stim_oe = one-hot bit k for SETTLE_CYCLES cycles. Sample on the last cycle:
  - resp[k]=1 sets pair_fail[k] (open).
  - any resp[j]=0 with j!=k sets pair_fail[j] and pair_fail[k] (short).
- RELEASE(k): stim_oe=0 for SETTLE_CYCLES cycles, no sampling. If k<NUM_PAIRS-1, increment k and return to DRIVE; otherwise go to CLK_SYNC.
- Phase counter: one counter, reloaded on each phase entry. Each phase lasts exactly SETTLE_CYCLES cycles.
- Edge detect: an edge pulse fires when the synchronised sck differs from its previous value (both directions count).
- CLK_SYNC: wait for the first edge pulse, then go to CLK_MEAS with the counter at 0. If EDGE_TIMEOUT cycles pass without an edge: clk_fail=1, measured_half_period=24'hFFFFFF, go to DONE.
- CLK_MEAS: the counter increments every cycle and saturates at 24'hFFFFFF.
  - On the next edge pulse, latch measured = counter+1, so an sck toggling every N cycles yields N.
  - clk_fail=1 if |measured - EXP_HALF_PERIOD| > HALF_PERIOD_TOL.
  - An EDGE_TIMEOUT expiry here behaves as in CLK_SYNC.
- DONE: busy=0, done=1, pass = (pair_fail==0 && !clk_fail). Results hold until the next start or reset.
- stim_oe is never multi-hot. A one-hot check is an assertion in the bench.
- Reset mid-run: FSM to IDLE, all results cleared, no partial done.

Test Plan:
Common bench parameters: NUM_PAIRS=4, SETTLE_CYCLES=8, EXP_HALF_PERIOD=100, HALF_PERIOD_TOL=2, EDGE_TIMEOUT=400.
1. Ideal DUT model (resp=~stim, sck toggles every 100 cycles), start pulse -> done=1, pass=1, pair_fail=4'b0000, clk_fail=0, measured_half_period=100. stim_oe sequence is 0,1,0,2,0,4,0,8, each for 8 cycles.
2. resp[2] tied high -> pair_fail=4'b0100, pass=0, clk_fail=0.
3. Pairs 1 and 3 shorted (resp[1]=resp[3]=~(stim[1]|stim[3])) -> pair_fail=4'b1010, pass=0.
4. resp[0] tied low -> baseline flags it, pair_fail=4'b0001 (no short flags on other pairs from resp[0]), pass=0.
5. sck half-period 110 -> clk_fail=1, measured_half_period=110. sck held constant -> clk_fail=1, measured=24'hFFFFFF, done=1.
6. Mid-run and restart behaviour:
   - rst_n low during DRIVE(2) -> stim_oe=0 immediately (asynchronously), busy=0, done=0.
   - start pulsed while busy -> no effect on the sequence.
   - start in DONE -> results cleared, full run repeats.
